// File: rtl/multicycle_decoder.sv
// Multi-cycle instruction decoder: an 11-state control FSM plus a multiply-latency
// counter. All control outputs are combinational from the state and the instruction fields.
module multicycle_decoder #(
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] Mul,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic       NoWrite,
  output logic       BL,
  output logic       busy,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] FlagW,
  output logic [2:0] ALUControl,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_MULWAIT = 4'd8,
    S_ALUWB   = 4'd9,
    S_BRANCH  = 4'd10
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  logic       i_bit;
  logic [3:0] cmd;
  logic       s_bit;
  logic       is_mul;
  logic       cnt_zero;
  logic [2:0] alu_dec;
  logic       cmp_dec;

  assign i_bit    = Funct[5];
  assign cmd      = Funct[4:1];
  assign s_bit    = Funct[0];
  assign is_mul   = (Op == 2'b00) && !i_bit && (cmd == 4'b0000) && (Mul == 4'b1001);
  assign cnt_zero = (cnt_q == '0);
  assign state_o  = state_q;

  // Data-processing command decode, shared by EXECR and EXECI.
  always_comb begin
    alu_dec = 3'b000;
    cmp_dec = 1'b0;
    case (cmd)
      4'b0100: alu_dec = 3'b000;
      4'b0010: alu_dec = 3'b001;
      4'b1010: begin
        alu_dec = 3'b001;
        cmp_dec = 1'b1;
      end
      4'b1100: alu_dec = 3'b011;
      4'b0000: alu_dec = 3'b010;
      4'b1101: alu_dec = i_bit ? 3'b101 : 3'b000;
      default: alu_dec = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_FETCH:  if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (Op)
            2'b00: begin
              if (is_mul) begin
                state_q <= S_MULWAIT;
                cnt_q   <= CNT_W'(MUL_LAT - 1);
              end else if (i_bit) begin
                state_q <= S_EXECI;
              end else begin
                state_q <= S_EXECR;
              end
            end
            2'b01:   state_q <= S_MEMADR;
            2'b10:   state_q <= S_BRANCH;
            default: state_q <= S_FETCH;
          endcase
        end
        S_MEMADR: state_q <= s_bit ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) state_q <= S_MEMWB;
        S_MEMWB:  state_q <= S_FETCH;
        S_MEMWR:  if (mem_ready) state_q <= S_FETCH;
        S_EXECR,
        S_EXECI:  state_q <= cmp_dec ? S_FETCH : S_ALUWB;
        S_MULWAIT: begin
          if (cnt_zero) state_q <= S_ALUWB;
          else          cnt_q   <= cnt_q - 1'b1;
        end
        S_ALUWB:  state_q <= S_FETCH;
        S_BRANCH: state_q <= S_FETCH;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    NoWrite    = 1'b0;
    BL         = 1'b0;
    busy       = (state_q != S_FETCH);
    ResultSrc  = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    FlagW      = 2'b00;
    ALUControl = 3'b000;
    case (state_q)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        NextPC    = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (Op == 2'b01 && !s_bit) RegSrc = 2'b10;
        if (Op == 2'b00 && i_bit)  ImmSrc = 2'b01;
        if (Op == 2'b10)           ImmSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
        NextPC    = (Rd == 4'd15);
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_EXECR,
      S_EXECI: begin
        ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl = alu_dec;
        NoWrite    = cmp_dec;
        FlagW      = {s_bit, s_bit & (alu_dec == 3'b000 || alu_dec == 3'b001)};
      end
      S_MULWAIT: begin
        ALUControl = 3'b100;
        FlagW      = {s_bit & cnt_zero, 1'b0};
      end
      S_ALUWB: begin
        RegW   = 1'b1;
        NextPC = (Rd == 4'd15);
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        NextPC    = 1'b1;
        BL        = Funct[4];
        RegW      = Funct[4];
      end
      default: ;
    endcase
    // Reset must suppress every architectural write strobe, even though FETCH is shown.
    if (!rst_n) begin
      IRWrite = 1'b0;
      NextPC  = 1'b0;
      RegW    = 1'b0;
      MemW    = 1'b0;
      FlagW   = 2'b00;
    end
  end

endmodule
